// File: rtl/pool_pkg.sv
// Shared constants and FSM encoding for the WQE buffer-pool chain allocator.
package pool_pkg;
  localparam int IDX_W = 10;
  localparam int LEN_W = 11;
  localparam int PTR_W = 9;

  localparam logic [PTR_W-1:0] PTR_NULL = '1;

  typedef enum logic [1:0] {INIT, IDLE, LINK, DONE} state_e;
endpackage

// File: rtl/pool_chain_alloc_if.sv
// Apply / free / table-write / descriptor signal bundle of pool_chain_alloc.
interface pool_chain_alloc_if
  import pool_pkg::*;
#(
  parameter int WQE_INDEX_WIDTH   = IDX_W,
  parameter int WQE_SOURCE_LENGTH = LEN_W,
  parameter int PTR_WIDTH         = PTR_W
);
  logic                         s_axis_Ptrapply_valid;
  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Ptrapply_id;
  logic                         s_axis_Ptrapply_ready;
  logic                         s_axis_Fapply_valid;
  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Fapply_id;
  logic [WQE_SOURCE_LENGTH-1:0] s_axis_Fapply_len;
  logic                         s_axis_Fapply_ready;
  logic                         s_axis_Pfree_valid;
  logic [PTR_WIDTH-1:0]         s_axis_Pfree_ptr;
  logic                         s_axis_Pfree_ready;
  logic                         m_next_wr_en;
  logic [PTR_WIDTH-1:0]         m_next_wr_addr;
  logic [PTR_WIDTH-1:0]         m_next_wr_data;
  logic                         m_axis_Palloc_valid;
  logic [WQE_INDEX_WIDTH-1:0]   m_axis_Palloc_id;
  logic [PTR_WIDTH-1:0]         m_axis_Palloc_head;
  logic [WQE_SOURCE_LENGTH-1:0] m_axis_Palloc_len;
  logic                         m_axis_Palloc_ready;

  modport slave (
    input  s_axis_Ptrapply_valid, s_axis_Ptrapply_id,
    input  s_axis_Fapply_valid, s_axis_Fapply_id, s_axis_Fapply_len,
    input  s_axis_Pfree_valid, s_axis_Pfree_ptr, m_axis_Palloc_ready,
    output s_axis_Ptrapply_ready, s_axis_Fapply_ready, s_axis_Pfree_ready,
    output m_next_wr_en, m_next_wr_addr, m_next_wr_data,
    output m_axis_Palloc_valid, m_axis_Palloc_id, m_axis_Palloc_head, m_axis_Palloc_len
  );

  modport master (
    output s_axis_Ptrapply_valid, s_axis_Ptrapply_id,
    output s_axis_Fapply_valid, s_axis_Fapply_id, s_axis_Fapply_len,
    output s_axis_Pfree_valid, s_axis_Pfree_ptr, m_axis_Palloc_ready,
    input  s_axis_Ptrapply_ready, s_axis_Fapply_ready, s_axis_Pfree_ready,
    input  m_next_wr_en, m_next_wr_addr, m_next_wr_data,
    input  m_axis_Palloc_valid, m_axis_Palloc_id, m_axis_Palloc_head, m_axis_Palloc_len
  );
endinterface

// File: rtl/pool_free_fifo.sv
// Free-slot pointer FIFO, depth 2^PTR_WIDTH, first-word-fall-through, push+pop same cycle.
module pool_free_fifo #(
  parameter int PTR_WIDTH = 9
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 push,
  input  logic [PTR_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [PTR_WIDTH-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [PTR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << PTR_WIDTH;

  logic [PTR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wp, rp;

  assign rd_data = mem[rp];
  assign empty   = (count == '0);
  assign full    = count[PTR_WIDTH];

  always_ff @(posedge sys_clk)
    if (push) mem[wp] <= push_data;

  // pointers wrap naturally at DEPTH
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PTR_WIDTH'(push);
      rp    <= rp + PTR_WIDTH'(pop);
      count <= count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
    end
endmodule

// File: rtl/pool_chain_alloc.sv
// Builds singly linked slot chains from apply beats and emits one descriptor per chain.
// Optional POOL_CHAIN_CHECK_EN adds the sticky chk_err protocol checker.
module pool_chain_alloc
  import pool_pkg::*;
#(
  parameter int WQE_INDEX_WIDTH   = IDX_W,
  parameter int WQE_SOURCE_LENGTH = LEN_W,
  parameter int PTR_WIDTH         = PTR_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  pool_chain_alloc_if.slave  bus,
  output logic [PTR_WIDTH:0] free_count,
  output logic               init_done
`ifdef POOL_CHAIN_CHECK_EN
  ,
  output logic               chk_err
`endif
);
  localparam logic [PTR_WIDTH-1:0]         NULLP   = '1;
  localparam logic [PTR_WIDTH-1:0]         LASTP   = NULLP - 1'b1;
  localparam logic [WQE_SOURCE_LENGTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [WQE_INDEX_WIDTH-1:0]   id;
    logic [PTR_WIDTH-1:0]         head;
    logic [WQE_SOURCE_LENGTH-1:0] len;
  } desc_t;

  state_e                       state;
  logic [PTR_WIDTH-1:0]         head, tail, term_ptr, init_ptr;
  logic [WQE_SOURCE_LENGTH-1:0] cnt, cnt_inc;
  logic [WQE_INDEX_WIDTH-1:0]   id_q;
  logic                         term_pend, desc_vld, wr_en;
  logic [PTR_WIDTH-1:0]         wr_addr, wr_data;
  desc_t                        desc_q;

  logic                 fifo_empty, fifo_full, push, pop;
  logic [PTR_WIDTH-1:0] fifo_rd, push_data;
  logic                 apply_rdy, pfree_rdy, ptr_acc, fin_acc, free_acc;

  // readies depend on registered state only
  assign apply_rdy = (state == IDLE || state == LINK) && !term_pend && !fifo_empty;
  assign pfree_rdy = (state != INIT) && !fifo_full;
  assign ptr_acc   = bus.s_axis_Ptrapply_valid && apply_rdy;
  assign fin_acc   = bus.s_axis_Fapply_valid && apply_rdy && !bus.s_axis_Ptrapply_valid;
  assign free_acc  = bus.s_axis_Pfree_valid && pfree_rdy;
  assign pop       = ptr_acc || fin_acc;
  assign push      = (state == INIT) || (free_acc && bus.s_axis_Pfree_ptr != NULLP);
  assign push_data = (state == INIT) ? init_ptr : bus.s_axis_Pfree_ptr;
  assign cnt_inc   = (state == IDLE) ? WQE_SOURCE_LENGTH'(1) :
                     (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  assign bus.s_axis_Ptrapply_ready = apply_rdy;
  assign bus.s_axis_Fapply_ready   = apply_rdy;
  assign bus.s_axis_Pfree_ready    = pfree_rdy;
  assign bus.m_next_wr_en          = wr_en;
  assign bus.m_next_wr_addr        = wr_addr;
  assign bus.m_next_wr_data        = wr_data;
  assign bus.m_axis_Palloc_valid   = desc_vld;
  assign bus.m_axis_Palloc_id      = desc_q.id;
  assign bus.m_axis_Palloc_head    = desc_q.head;
  assign bus.m_axis_Palloc_len     = desc_q.len;

  pool_free_fifo #(.PTR_WIDTH(PTR_WIDTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (free_count)
  );

  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state     <= INIT;
      init_ptr  <= '0;
      init_done <= 1'b0;
      head      <= '0;
      tail      <= '0;
      term_ptr  <= '0;
      cnt       <= '0;
      id_q      <= '0;
      term_pend <= 1'b0;
      desc_vld  <= 1'b0;
      desc_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LASTP) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE, LINK: begin
          if (term_pend) begin
            term_pend <= 1'b0;
            wr_en     <= 1'b1;
            wr_addr   <= term_ptr;
            wr_data   <= NULLP;
            desc_vld  <= 1'b1;
            state     <= DONE;
          end else if (ptr_acc) begin
            cnt  <= cnt_inc;
            tail <= fifo_rd;
            if (state == IDLE) begin
              head  <= fifo_rd;
              id_q  <= bus.s_axis_Ptrapply_id;
              state <= LINK;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= tail;
              wr_data <= fifo_rd;
            end
          end else if (fin_acc) begin
            desc_q <= '{id:   (state == IDLE) ? bus.s_axis_Fapply_id : id_q,
                        head: (state == IDLE) ? fifo_rd : head,
                        len:  cnt_inc};
            wr_en  <= 1'b1;
            // open chain: link write now, terminator on the following cycle
            if (state == IDLE) begin
              wr_addr  <= fifo_rd;
              wr_data  <= NULLP;
              desc_vld <= 1'b1;
              state    <= DONE;
            end else begin
              wr_addr   <= tail;
              wr_data   <= fifo_rd;
              term_ptr  <= fifo_rd;
              term_pend <= 1'b1;
            end
          end
        end
        DONE:
          if (bus.m_axis_Palloc_ready) begin
            desc_vld <= 1'b0;
            state    <= IDLE;
          end
        default: state <= INIT;
      endcase
    end

`ifdef POOL_CHAIN_CHECK_EN
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) chk_err <= 1'b0;
    else if ((fin_acc && bus.s_axis_Fapply_len != cnt_inc) ||
             (ptr_acc && state == LINK && bus.s_axis_Ptrapply_id != id_q) ||
             (free_acc && bus.s_axis_Pfree_ptr == NULLP))
      chk_err <= 1'b1;
`else
  logic unused_len;
  assign unused_len = ^bus.s_axis_Fapply_len;
`endif
endmodule

// File: tb/tb_pool_chain_alloc.sv
// Bench for pool_chain_alloc: queue-based free-list/chain model, directed cases then random traffic.
module tb_pool_chain_alloc;
  import pool_pkg::*;
  localparam int PW    = PTR_W;
  localparam int NPTR  = (1 << PW) - 1;
  localparam int NULLV = NPTR;
  localparam int LMAX  = (1 << LEN_W) - 1;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [PW:0] free_count;
  logic init_done;
`ifdef POOL_CHAIN_CHECK_EN
  logic chk_err;
`endif

  pool_chain_alloc_if bus ();

  pool_chain_alloc dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .bus        (bus),
    .free_count (free_count),
    .init_done  (init_done)
`ifdef POOL_CHAIN_CHECK_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, passed = 0, cyc = 0;
  // stimulus
  int pv, pid, fv, fid, flen, rv, rptr, ar, sel_idx;
  // model
  int fl[$], chain[$], alloc[$], d_chain[$];
  int ew_c[$], ew_a[$], ew_d[$];
  int wlog_a[$], wlog_d[$];
  bit m_init, m_closing, m_desc_pend, m_chk;
  int init_idx, m_desc_cyc, m_id, d_id, d_head, d_len;
  int last_id, last_head, last_len;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic sched(int c, int a, int d);
    ew_c.push_back(c); ew_a.push_back(a); ew_d.push_back(d);
  endtask

  task automatic clr_stim();
    pv = 0; pid = 0; fv = 0; fid = 0; flen = 0; rv = 0; rptr = 0; ar = 0; sel_idx = -1;
  endtask

  task automatic cycle();
    int p, ln;
    bit ar_exp, pacc, facc, racc, dacc;
    bus.s_axis_Ptrapply_valid = pv[0];
    bus.s_axis_Ptrapply_id    = IDX_W'(pid);
    bus.s_axis_Fapply_valid   = fv[0];
    bus.s_axis_Fapply_id      = IDX_W'(fid);
    bus.s_axis_Fapply_len     = LEN_W'(flen);
    bus.s_axis_Pfree_valid    = rv[0];
    bus.s_axis_Pfree_ptr      = PW'(rptr);
    bus.m_axis_Palloc_ready   = ar[0];
    ar_exp = m_init && !m_closing && fl.size() > 0;
    chk("ptr_ready", int'(bus.s_axis_Ptrapply_ready), int'(ar_exp));
    chk("fin_ready", int'(bus.s_axis_Fapply_ready), int'(ar_exp));
    chk("pfree_ready", int'(bus.s_axis_Pfree_ready), int'(m_init && fl.size() < NPTR + 1));
    pacc = pv[0] && ar_exp;
    facc = fv[0] && ar_exp && !pv[0];
    racc = rv[0] && m_init && fl.size() < NPTR + 1;
    dacc = m_desc_pend && cyc >= m_desc_cyc && ar[0];
    if (dacc) begin
      last_id = bus.m_axis_Palloc_id; last_head = bus.m_axis_Palloc_head;
      last_len = bus.m_axis_Palloc_len;
      foreach (d_chain[i]) alloc.push_back(d_chain[i]);
      m_desc_pend = 0; m_closing = 0;
    end
    if (pacc) begin
      p = fl.pop_front();
      if (chain.size() == 0) m_id = pid;
      else begin
        sched(cyc + 1, chain[$], p);
        if (pid != m_id) m_chk = 1;
      end
      chain.push_back(p);
    end
    if (facc) begin
      p = fl.pop_front();
      if (chain.size() == 0) begin
        d_id = fid; sched(cyc + 1, p, NULLV); m_desc_cyc = cyc + 1;
      end else begin
        d_id = m_id; sched(cyc + 1, chain[$], p); sched(cyc + 2, p, NULLV);
        m_desc_cyc = cyc + 2;
      end
      chain.push_back(p);
      d_head = chain[0];
      ln = (chain.size() > LMAX) ? LMAX : chain.size();
      d_len = ln;
      if (flen != ln) m_chk = 1;
      d_chain = chain; chain.delete();
      m_closing = 1; m_desc_pend = 1;
    end
    if (racc) begin
      if (rptr != NULLV) begin
        fl.push_back(rptr);
        if (sel_idx >= 0) alloc.delete(sel_idx);
      end else m_chk = 1;
    end
    if (!m_init) begin
      fl.push_back(init_idx); init_idx++;
      if (init_idx == NPTR) m_init = 1;
    end
    @(negedge sys_clk);
    cyc++;
    if (bus.m_next_wr_en) begin
      wlog_a.push_back(bus.m_next_wr_addr); wlog_d.push_back(bus.m_next_wr_data);
    end
    if (ew_c.size() > 0 && ew_c[0] == cyc) begin
      chk("wr_en", int'(bus.m_next_wr_en), 1);
      chk("wr_addr", int'(bus.m_next_wr_addr), ew_a[0]);
      chk("wr_data", int'(bus.m_next_wr_data), ew_d[0]);
      void'(ew_c.pop_front()); void'(ew_a.pop_front()); void'(ew_d.pop_front());
    end else chk("wr_en_quiet", int'(bus.m_next_wr_en), 0);
    chk("desc_valid", int'(bus.m_axis_Palloc_valid), int'(m_desc_pend && cyc >= m_desc_cyc));
    if (m_desc_pend && cyc >= m_desc_cyc) begin
      chk("desc_id", int'(bus.m_axis_Palloc_id), d_id);
      chk("desc_head", int'(bus.m_axis_Palloc_head), d_head);
      chk("desc_len", int'(bus.m_axis_Palloc_len), d_len);
    end
    chk("free_count", int'(free_count), fl.size());
    chk("init_done", int'(init_done), int'(m_init));
`ifdef POOL_CHAIN_CHECK_EN
    chk("chk_err", int'(chk_err), int'(m_chk));
`endif
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    clr_stim();
    bus.s_axis_Ptrapply_valid = 0; bus.s_axis_Fapply_valid = 0;
    bus.s_axis_Pfree_valid = 0; bus.m_axis_Palloc_ready = 0;
    repeat (3) @(negedge sys_clk);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_free_count", int'(free_count), 0);
    chk("rst_ptr_ready", int'(bus.s_axis_Ptrapply_ready), 0);
    chk("rst_pfree_ready", int'(bus.s_axis_Pfree_ready), 0);
    chk("rst_desc_valid", int'(bus.m_axis_Palloc_valid), 0);
    chk("rst_wr_en", int'(bus.m_next_wr_en), 0);
    fl.delete(); chain.delete(); alloc.delete(); d_chain.delete();
    ew_c.delete(); ew_a.delete(); ew_d.delete();
    m_init = 0; m_closing = 0; m_desc_pend = 0; m_chk = 0; init_idx = 0;
    sys_rst = 1'b0;
  endtask

  task automatic run_init();
    repeat (NPTR - 1) cycle();
    chk("init_not_yet", int'(init_done), 0);
    chk("init_ready_low", int'(bus.s_axis_Pfree_ready), 0);
    cycle();
    chk("init_done_511", int'(init_done), 1);
    chk("init_count_511", int'(free_count), 511);
  endtask

  initial begin
    int n;
    clr_stim();
    // single-beat chain
    do_reset(); run_init();
    fv = 1; fid = 5; flen = 1; cycle(); clr_stim(); cycle();
    chk("t1_wr_addr", wlog_a[$], 0);
    chk("t1_wr_data", wlog_d[$], 511);
    chk("t1_head", int'(bus.m_axis_Palloc_head), 0);
    ar = 1; cycle(); clr_stim();
    chk("t1_id", last_id, 5);
    chk("t1_len", last_len, 1);

    // three-slot chain, then back-pressure on the descriptor
    do_reset(); run_init();
    wlog_a.delete(); wlog_d.delete();
    pv = 1; pid = 3; cycle(); cycle(); clr_stim();
    fv = 1; fid = 3; flen = 3; cycle(); clr_stim();
    cycle(); cycle();
    chk("t2_nwr", wlog_a.size(), 3);
    chk("t2_w0", wlog_a[0] * 1000 + wlog_d[0], 1);
    chk("t2_w1", wlog_a[1] * 1000 + wlog_d[1], 1002);
    chk("t2_w2", wlog_a[2] * 1000 + wlog_d[2], 2511);
    chk("t2_count", int'(free_count), 508);
    repeat (10) cycle();
    chk("t3_head_held", int'(bus.m_axis_Palloc_head), 0);
    chk("t3_len_held", int'(bus.m_axis_Palloc_len), 3);
    chk("t3_ready_low", int'(bus.s_axis_Ptrapply_ready), 0);
    ar = 1; cycle(); clr_stim();
    chk("t3_len", last_len, 3);

`ifdef POOL_CHAIN_CHECK_EN
    do_reset(); run_init();
    pv = 1; pid = 4; cycle(); cycle(); clr_stim();
    fv = 1; fid = 4; flen = 5; cycle(); clr_stim();
    cycle(); cycle();
    chk("t5_chk_err", int'(chk_err), 1);
    chk("t5_len", int'(bus.m_axis_Palloc_len), 3);
    ar = 1; cycle(); clr_stim(); repeat (3) cycle();
    chk("t5_sticky", int'(chk_err), 1);
`endif

    // drain the free list, then refill one slot
    do_reset(); run_init();
    n = 0;
    pv = 1; pid = 9;
    while (fl.size() > 0 && n < 600) begin cycle(); n++; end
    chk("t4_drain_bound", int'(n < 600), 1);
    clr_stim(); cycle();
    chk("t4_empty_ready", int'(bus.s_axis_Ptrapply_ready), 0);
    chk("t4_empty_count", int'(free_count), 0);
    rv = 1; rptr = 7; cycle(); clr_stim(); cycle();
    chk("t4_ready_back", int'(bus.s_axis_Fapply_ready), 1);
    fv = 1; fid = 9; flen = 512; cycle(); clr_stim(); cycle(); cycle();
    chk("t4_link", wlog_a[wlog_a.size()-2] * 1000 + wlog_d[wlog_d.size()-2], 510007);
    chk("t4_term", wlog_a[$] * 1000 + wlog_d[$], 7511);
    chk("t4_len", int'(bus.m_axis_Palloc_len), 512);
    ar = 1; cycle(); clr_stim();

    // random traffic with a reset in the middle of it
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(); run_init();
      for (int i = 0; i < 2500; i++) begin
        clr_stim();
        pv = ($urandom_range(3) == 0); pid = $urandom_range(3);
        fv = ($urandom_range(5) == 0); fid = $urandom_range(1023);
        flen = $urandom_range(4);
        ar = ($urandom_range(2) != 0);
        if ($urandom_range(20) == 0) begin rv = 1; rptr = NULLV; end
        else if (alloc.size() > 0 && $urandom_range(2) == 0) begin
          rv = 1; sel_idx = $urandom_range(alloc.size() - 1); rptr = alloc[sel_idx];
        end
        cycle();
      end
    end
    clr_stim(); ar = 1;
    repeat (5) cycle();
    chk("no_pending_writes", ew_c.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pool_chain_alloc.md
Name: pool_chain_alloc

Overview:
- Responder side of the WQE buffer-pool apply protocol: consumes the per-WQE pointer-apply beats (Ptrapply) and the final-apply beat (Fapply) produced by the pool apply front-end.
- For each apply beat, pops a free slot pointer from an internal free list and builds a singly linked chain by emitting next-pointer table writes.
- When the chain is closed, emits one chain descriptor (id, head, length). Freed slots return through a separate stream.

Parameters:
- WQE_INDEX_WIDTH, 10, width of WQE id.
- WQE_SOURCE_LENGTH, 11, width of chain length field.
- PTR_WIDTH, 9, slot pointer width. Pointers 0..2^PTR_WIDTH-2 are allocatable; all-ones is NULL (end of chain).

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset
- s_axis_Ptrapply_valid  in  1  non-final apply beat
- s_axis_Ptrapply_id  in  WQE_INDEX_WIDTH  WQE id of the beat
- s_axis_Ptrapply_ready  out  1  beat accepted
- s_axis_Fapply_valid  in  1  final apply beat
- s_axis_Fapply_id  in  WQE_INDEX_WIDTH  WQE id
- s_axis_Fapply_len  in  WQE_SOURCE_LENGTH  requested chain length
- s_axis_Fapply_ready  out  1  final beat accepted
- s_axis_Pfree_valid  in  1  returned slot
- s_axis_Pfree_ptr  in  PTR_WIDTH  slot being freed
- s_axis_Pfree_ready  out  1  free accepted
- m_next_wr_en  out  1  next-pointer table write strobe
- m_next_wr_addr  out  PTR_WIDTH  slot being linked
- m_next_wr_data  out  PTR_WIDTH  successor pointer, or NULL
- m_axis_Palloc_valid  out  1  chain descriptor valid
- m_axis_Palloc_id  out  WQE_INDEX_WIDTH  WQE id
- m_axis_Palloc_head  out  PTR_WIDTH  first slot of chain
- m_axis_Palloc_len  out  WQE_SOURCE_LENGTH  counted slots (Ptr beats + 1)
- m_axis_Palloc_ready  in  1  descriptor consumed
- free_count  out  PTR_WIDTH+1  current free-list occupancy
- init_done  out  1  free list fully seeded

Behaviour:
- Reset: sys_rst is asynchronous, active-high; clock is sys_clk. All outputs reset to 0: valids, readies, m_next_wr_en, init_done, free_count.
- FSM states: INIT, IDLE, LINK, DONE. Reset enters INIT.
- INIT:
  - Pushes pointers 0..2^PTR_WIDTH-2 into the free list, one per cycle, in ascending order.
  - On the last push, sets init_done=1 and moves to IDLE.
  - All s_axis readies are 0 during INIT.
- Ready generation: readies are functions of registered state only, with no combinational valid-to-ready path.
  - Ptrapply_ready = Fapply_ready = (IDLE or LINK) and free list non-empty.
  - Pfree_ready = not INIT and free list not full.
- Ptrapply accepted in IDLE:
  - Pop ptr P; head=P, tail=P, cnt=1, latch id; go to LINK.
  - No table write.
- Ptrapply accepted in LINK:
  - Pop P; cnt+1.
  - Next cycle: m_next_wr_en=1, addr=tail, data=P. Then tail=P.
- Fapply accepted in IDLE or LINK:
  - Pop P. In IDLE, head=P and id is taken from Fapply.
  - Next cycle: the link write (tail->P) if in LINK, and in every case the terminating write (P->NULL).
  - Two writes on consecutive cycles: link first, terminator second. Readies are 0 meanwhile.
  - Then go to DONE.
  - Descriptor valid asserts in the same cycle as the terminator write.
- DONE: hold m_axis_Palloc_* stable while valid && !ready. On the handshake, drop valid and go to IDLE.
- Both apply valids in the same cycle: Ptrapply wins; Fapply waits.
- Counters:
  - cnt saturates at 2^WQE_SOURCE_LENGTH-1; beats beyond that still link.
  - Ptrapply beats in LINK with an id different from the latched id are still linked to the open chain.
- Free list:
  - Pfree push and apply pop in the same cycle both occur; free_count is unchanged.
  - Pop while empty is impossible (ready gated).
  - Freeing the NULL pointer is accepted and discarded.
- Reset mid-chain: partial chain is abandoned and the free list is reseeded from scratch.

Optional Feature:
- Macro: POOL_CHAIN_CHECK_EN.
- Defined: adds output chk_err (1 bit, sticky, cleared only by reset). It sets when:
  - Fapply_len != counted length at Fapply acceptance, or
  - a LINK-state Ptrapply id != latched id, or
  - a Pfree ptr is NULL.
- Descriptor len always carries the counted value.
- Undefined: no chk_err port and no compare logic; behaviour is otherwise identical.

Decomposition:
- Shared package pool_pkg:
  - NULL pointer constant (all ones, PTR_WIDTH);
  - FSM state encoding;
  - descriptor field widths.
- One sub-module: pool_free_fifo, a synchronous pointer FIFO.
  - Depth 2^PTR_WIDTH.
  - Simultaneous push/pop.
  - Ports: empty, full, count; first-word-fall-through read data.

Test Plan:
- Reset release -> init_done after 511 cycles; free_count=511; readies 0 until then.
- Fapply id=5 len=1 in IDLE -> one write (0->NULL); descriptor id=5 head=0 len=1.
- Ptr beats id=3 x2, then Fapply id=3 len=3 -> writes 0->1, 1->2, 2->NULL; descriptor head=0 len=3; free_count=508.
- Descriptor with Palloc_ready held low 10 cycles -> fields stable; apply readies 0 throughout.
- Drain free list to 0 -> apply readies drop. Pfree ptr=7 -> ready returns; next pop yields 7.
- With POOL_CHAIN_CHECK_EN: 2 Ptr beats then Fapply len=5 -> chk_err=1 sticky; descriptor len=3.
